inv_sub_arbiter: RTL and testbench

INV_SUB_ARBITER -- requirements
Module: inv_sub_arbiter

---
 rtl/inv_sub_arbiter.sv | 119 +++++++++++
 tb/tb_inv_sub_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/inv_sub_arbiter.sv
// Two-requester arbiter that feeds one shared 4-bit inverse S-box,
// substituting a 16-bit word one nibble per cycle, MSB nibble first.
module inv_sub_arbiter #(
    parameter bit PRIO_RESET = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_data,
    output logic        req1_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_id,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cnt;
    logic [15:0] r_word;
    logic [15:0] r_res;
    logic        r_id;
    logic        r_last;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_acc;
    logic [1:0]  w_pos;
    logic [3:0]  w_nib_in;
    logic [3:0]  w_nib_out;

    // Tie goes to whoever was not served last
    assign w_gnt0 = req0_valid & (~req1_valid | r_last);
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last);
    assign w_acc  = req0_ready | req1_ready;

    // Counter 0 addresses bits [15:12]
    assign w_pos    = 2'd3 - r_cnt;
    assign w_nib_in = r_word[{w_pos, 2'b00} +: 4];

    always_comb begin
        w_nib_out = 4'h0;
        unique case (w_nib_in)
            4'h0: w_nib_out = 4'hA;
            4'h1: w_nib_out = 4'h5;
            4'h2: w_nib_out = 4'h9;
            4'h3: w_nib_out = 4'hB;
            4'h4: w_nib_out = 4'h1;
            4'h5: w_nib_out = 4'h7;
            4'h6: w_nib_out = 4'h8;
            4'h7: w_nib_out = 4'hF;
            4'h8: w_nib_out = 4'h6;
            4'h9: w_nib_out = 4'h0;
            4'hA: w_nib_out = 4'h2;
            4'hB: w_nib_out = 4'h3;
            4'hC: w_nib_out = 4'hC;
            4'hD: w_nib_out = 4'h4;
            4'hE: w_nib_out = 4'hD;
            4'hF: w_nib_out = 4'hE;
            default: w_nib_out = 4'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_acc) w_next = SUB;
            SUB:     if (r_cnt == 2'd3) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = ~rst & (r_state == IDLE) & w_gnt0;
        req1_ready = ~rst & (r_state == IDLE) & w_gnt1;
        out_valid  = (r_state == DONE);
        out_data   = r_res;
        out_id     = r_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 2'd0;
            r_word <= 16'h0000;
            r_res  <= 16'h0000;
            r_id   <= 1'b0;
            r_last <= ~PRIO_RESET;
        end else begin
            if (r_state == IDLE && w_acc) begin
                r_word <= req1_ready ? req1_data : req0_data;
                r_id   <= req1_ready;
                r_last <= req1_ready;
                r_cnt  <= 2'd0;
            end else if (r_state == SUB) begin
                r_res[{w_pos, 2'b00} +: 4] <= w_nib_out;
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_inv_sub_arbiter.sv
// Directed bench for inv_sub_arbiter: latency, lookup table,
// round-robin grants, output hold and mid-operation reset.
module tb_inv_sub_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic [15:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_data;
    logic        req1_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_id;
    logic        out_ready;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inv_sub_arbiter #(.PRIO_RESET(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one word from an idle DUT and checks the full transaction
    task automatic word(input bit id, input logic [15:0] d,
                        input logic [15:0] e, input int hold);
        out_ready = (hold == 0);
        if (id) begin
            req1_valid = 1'b1;
            req1_data  = d;
        end else begin
            req0_valid = 1'b1;
            req0_data  = d;
        end
        #1;
        chk("ready", id ? req1_ready : req0_ready, 1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("lat_valid", out_valid, (i == 4));
        end
        chk("data", out_data, e);
        chk("id", out_id, id);
        for (int h = 0; h < hold; h++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            step();
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, e);
            chk("hold_id", out_id, id);
            chk("hold_rdy", {req1_ready, req0_ready}, 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        step();
        chk("idle_valid", out_valid, 0);
    endtask

    initial begin
        bit seen;
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 16'h1234;
        req1_valid = 1'b1;
        req1_data  = 16'h5678;
        out_ready  = 1'b1;
        step();
        step();
        chk("rst_rdy", {req1_ready, req0_ready}, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 16'h0000);
        chk("rst_id", out_id, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        step();

        word(1'b0, 16'h0123, 16'hA59B, 0);
        word(1'b1, 16'h89CD, 16'h60C4, 0);
        word(1'b1, 16'hFFFF, 16'hEEEE, 0);
        word(1'b0, 16'hABEF, 16'h23DE, 0);
        word(1'b1, 16'h4567, 16'h178F, 3);

        // Round-robin from reset with both requesters always valid
        rst = 1'b1;
        step();
        rst        = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 16'h0123;
        req1_valid = 1'b1;
        req1_data  = 16'hFFFF;
        out_ready  = 1'b1;
        #1;
        for (int w = 0; w < 4; w++) begin
            chk("rr_gnt1", req1_ready, w[0]);
            chk("rr_gnt0", req0_ready, !w[0]);
            step();
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                step();
                seen = out_valid;
            end
            chk("rr_done", seen, 1);
            chk("rr_id", out_id, w[0]);
            chk("rr_data", out_data, w[0] ? 16'hEEEE : 16'hA59B);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        step();

        // Reset during the second SUB cycle aborts the word
        req0_valid = 1'b1;
        req0_data  = 16'h0123;
        step();
        req0_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        chk("abort_valid", seen, 0);
        chk("abort_data", out_data, 16'h0000);
        word(1'b0, 16'h4567, 16'h178F, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
